// File: rtl/pll_lock_monitor_if.sv
// Status/handshake bundle between the ADPLL controller and its lock monitor.
// The slave side is the monitor; the master side is the PLL/relock controller.
interface pll_lock_monitor_if #(
  parameter int WIN = 16
);
  localparam int BW = $clog2(WIN) + 2;

  logic          locked_in;
  logic          dir_valid;
  logic          direction;
  logic          relock_ack;
  logic          lock_ok;
  logic          lock_lost;
  logic          relock_req;
  logic [BW-1:0] bias;
  logic          bias_valid;

  modport slave (
    input  locked_in, dir_valid, direction, relock_ack,
    output lock_ok, lock_lost, relock_req, bias, bias_valid
  );

  modport master (
    output locked_in, dir_valid, direction, relock_ack,
    input  lock_ok, lock_lost, relock_req, bias, bias_valid
  );
endinterface

// File: rtl/pll_lock_monitor.sv
// Post-lock supervisor: waits a settle time after lock, accumulates phase
// detector early/late decisions per window and requests relock on drift.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for the PLL to report lock
//   SETTLE  | lock seen, down-counting the settle time, PD ignored
//   MONITOR | lock good, accumulating PD bias per window
//   LOST    | drift persisted, holding relock request until acked
module pll_lock_monitor #(
  parameter int WIN      = 16,
  parameter int THRESH   = 4,
  parameter int SETTLE   = 8,
  parameter int LOSS_WIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  pll_lock_monitor_if.slave mon
);
  localparam int AW = $clog2(WIN) + 2;
  localparam int CW = $clog2(WIN) + 1;
  localparam int DW = $clog2(LOSS_WIN + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE_ST, MONITOR, LOST} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic [CW-1:0] smp_cnt, smp_nxt;
  logic [DW-1:0] drift_cnt, drift_nxt;
  logic [AW-1:0] bias_q, bias_nxt;
  logic          bias_valid_q, bias_valid_nxt;
  logic          lock_ok_q, lock_ok_nxt;
  logic          lock_lost_q, lock_lost_nxt;
  logic          relock_q, relock_nxt;

  // Window arithmetic including the sample arriving this cycle.
  logic [AW-1:0] sample_acc;
  logic [CW-1:0] sample_cnt;
  logic [AW:0]   acc_ext;
  logic [AW:0]   mag;
  logic [DW-1:0] drift_inc;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      acc          <= '0;
      smp_cnt      <= '0;
      drift_cnt    <= '0;
      bias_q       <= '0;
      bias_valid_q <= 1'b0;
      lock_ok_q    <= 1'b0;
      lock_lost_q  <= 1'b0;
      relock_q     <= 1'b0;
    end else begin
      state        <= state_nxt;
      settle_cnt   <= settle_nxt;
      acc          <= acc_nxt;
      smp_cnt      <= smp_nxt;
      drift_cnt    <= drift_nxt;
      bias_q       <= bias_nxt;
      bias_valid_q <= bias_valid_nxt;
      lock_ok_q    <= lock_ok_nxt;
      lock_lost_q  <= lock_lost_nxt;
      relock_q     <= relock_nxt;
    end
  end

  // Next-state, counters, window evaluation and registered-output targets.
  always_comb begin
    state_nxt      = state;
    settle_nxt     = settle_cnt;
    acc_nxt        = acc;
    smp_nxt        = smp_cnt;
    drift_nxt      = drift_cnt;
    bias_nxt       = bias_q;
    bias_valid_nxt = 1'b0;
    lock_ok_nxt    = lock_ok_q;
    lock_lost_nxt  = lock_lost_q;
    relock_nxt     = relock_q;

    sample_acc = mon.direction ? (acc + AW'(1)) : (acc - AW'(1));
    sample_cnt = smp_cnt + CW'(1);
    // Sign-extend before negating so that -WIN yields +WIN.
    acc_ext    = {sample_acc[AW-1], sample_acc};
    mag        = acc_ext[AW] ? (~acc_ext + (AW+1)'(1)) : acc_ext;
    drift_inc  = drift_cnt + DW'(1);

    unique case (state)
      IDLE: begin
        lock_ok_nxt = 1'b0;
        if (mon.locked_in) begin
          state_nxt  = SETTLE_ST;
          settle_nxt = SW'(SETTLE - 1);
        end
      end
      SETTLE_ST: begin
        if (!mon.locked_in) begin
          state_nxt   = IDLE;
          lock_ok_nxt = 1'b0;
        end else if (settle_cnt == '0) begin
          state_nxt   = MONITOR;
          lock_ok_nxt = 1'b1;
        end else begin
          settle_nxt = settle_cnt - SW'(1);
        end
      end
      MONITOR: begin
        if (!mon.locked_in) begin
          // Unlock wins over a coincident window end; bias is kept.
          state_nxt   = IDLE;
          lock_ok_nxt = 1'b0;
          acc_nxt     = '0;
          smp_nxt     = '0;
          drift_nxt   = '0;
        end else if (mon.dir_valid) begin
          if (sample_cnt == CW'(WIN)) begin
            bias_nxt       = sample_acc;
            bias_valid_nxt = 1'b1;
            acc_nxt        = '0;
            smp_nxt        = '0;
            if (mag >= (AW+1)'(THRESH)) begin
              if (drift_inc == DW'(LOSS_WIN)) begin
                state_nxt     = LOST;
                lock_ok_nxt   = 1'b0;
                lock_lost_nxt = 1'b1;
                relock_nxt    = 1'b1;
                drift_nxt     = '0;
              end else begin
                drift_nxt = drift_inc;
              end
            end else begin
              drift_nxt = '0;
            end
          end else begin
            acc_nxt = sample_acc;
            smp_nxt = sample_cnt;
          end
        end
      end
      LOST: begin
        if (mon.relock_ack) begin
          state_nxt     = IDLE;
          lock_lost_nxt = 1'b0;
          relock_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mon.lock_ok    = lock_ok_q;
  assign mon.lock_lost  = lock_lost_q;
  assign mon.relock_req = relock_q;
  assign mon.bias       = bias_q;
  assign mon.bias_valid = bias_valid_q;
endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed plus randomized bench for pll_lock_monitor (WIN=16, THRESH=4,
// SETTLE=8, LOSS_WIN=2). Expected window bias comes from counting early
// decisions in each window; drift/loss from a consecutive-window counter.
module tb_pll_lock_monitor;
  localparam int WIN      = 16;
  localparam int THRESH   = 4;
  localparam int SETTLE   = 8;
  localparam int LOSS_WIN = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   drift_m;
  int   last_bias;
  logic lost_flag;

  pll_lock_monitor_if #(.WIN(WIN)) bus ();

  pll_lock_monitor #(
    .WIN(WIN), .THRESH(THRESH), .SETTLE(SETTLE), .LOSS_WIN(LOSS_WIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int v);
    logic [5:0] b;
    b = v[5:0];
    return {26'b0, b};
  endfunction

  // Count cycles from locked_in high (IDLE) until lock_ok; optional PD noise.
  task automatic wait_lock(input bit noise);
    int n;
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      if (noise) begin
        bus.dir_valid = 1'($urandom_range(1, 0));
        bus.direction = 1'($urandom_range(1, 0));
      end
      step();
      if (bus.lock_ok === 1'b1) n = k;
    end
    bus.dir_valid = 1'b0;
    chk("lock_latency", n, SETTLE + 1);
    drift_m = 0;
  endtask

  // Feed one full window (bit 0 first) and check against the model.
  task automatic send_window(input logic [15:0] pat, input int gapmax, output logic lost);
    int ones;
    int b;
    int mag;
    ones = 0;
    for (int i = 0; i < WIN; i++) begin
      bus.dir_valid = 1'b1;
      bus.direction = pat[i];
      ones += int'(pat[i]);
      step();
      bus.dir_valid = 1'b0;
      if (i < WIN - 1) begin
        if (i == WIN / 2) chk("bias_valid_mid", bus.bias_valid, 0);
        for (int g = 0; g < int'($urandom_range(gapmax, 0)); g++) step();
      end
    end
    b   = 2 * ones - WIN;
    mag = (b < 0) ? -b : b;
    last_bias = b;
    if (mag >= THRESH) drift_m++;
    else drift_m = 0;
    lost = (drift_m == LOSS_WIN);
    if (lost) drift_m = 0;
    chk("bias_valid", bus.bias_valid, 1);
    chk("bias", bus.bias, enc(b));
    chk("lock_lost", bus.lock_lost, lost);
    chk("relock_req", bus.relock_req, lost);
    chk("lock_ok", bus.lock_ok, !lost);
    step();
    chk("bias_valid_pulse", bus.bias_valid, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drift_m = 0;
    last_bias = 0;
    rst = 1'b1;
    bus.locked_in  = 1'b0;
    bus.dir_valid  = 1'b0;
    bus.direction  = 1'b0;
    bus.relock_ack = 1'b0;

    // Reset and lock rise
    step();
    step();
    chk("rst_lock_ok", bus.lock_ok, 0);
    chk("rst_lock_lost", bus.lock_lost, 0);
    chk("rst_relock_req", bus.relock_req, 0);
    chk("rst_bias", bus.bias, 0);
    chk("rst_bias_valid", bus.bias_valid, 0);
    rst = 1'b0;
    bus.locked_in = 1'b1;
    wait_lock(1'b1);

    // Balanced PD, with a stray ack while monitoring
    send_window(16'h5555, 0, lost_flag);
    bus.relock_ack = 1'b1;
    step();
    bus.relock_ack = 1'b0;
    chk("ack_ignored_lock_ok", bus.lock_ok, 1);
    chk("ack_ignored_relock", bus.relock_req, 0);
    send_window(16'hAAAA, 1, lost_flag);

    // Drift reset: -16, +2, -16 never reaches two in a row
    send_window(16'h0000, 0, lost_flag);
    chk("raw_minus16", bus.bias, 32'b110000);
    send_window(16'h01FF, 1, lost_flag);
    chk("raw_plus2", bus.bias, 32'b000010);
    send_window(16'h0000, 0, lost_flag);
    chk("no_loss", bus.lock_lost, 0);

    // Loss detection
    send_window(16'h5555, 0, lost_flag);
    send_window(16'hFFFF, 0, lost_flag);
    send_window(16'hFFFF, 1, lost_flag);
    chk("loss_declared", lost_flag, 1);
    for (int k = 0; k < 10; k++) begin
      bus.locked_in = 1'(k % 2);
      bus.dir_valid = 1'b1;
      step();
      chk("held_lost", bus.lock_lost, 1);
      chk("held_req", bus.relock_req, 1);
    end
    bus.dir_valid = 1'b0;
    bus.locked_in = 1'b1;
    bus.relock_ack = 1'b1;
    step();
    bus.relock_ack = 1'b0;
    chk("ack_lost", bus.lock_lost, 0);
    chk("ack_req", bus.relock_req, 0);
    chk("ack_lock_ok", bus.lock_ok, 0);
    chk("ack_bias_kept", bus.bias, enc(last_bias));
    wait_lock(1'b1);

    // Unlock colliding with the 16th sample
    for (int i = 0; i < WIN; i++) begin
      bus.dir_valid = 1'b1;
      bus.direction = 1'b1;
      if (i == WIN - 1) bus.locked_in = 1'b0;
      step();
    end
    bus.dir_valid = 1'b0;
    chk("collide_bias_valid", bus.bias_valid, 0);
    chk("collide_lock_ok", bus.lock_ok, 0);
    chk("collide_bias", bus.bias, enc(last_bias));
    bus.locked_in = 1'b1;
    wait_lock(1'b0);
    send_window(16'h5555, 0, lost_flag);

    // Randomized windows against the model
    for (int w = 0; w < 12; w++) begin
      send_window(16'($urandom), 2, lost_flag);
      if (lost_flag) begin
        for (int g = 0; g < int'($urandom_range(3, 0)); g++) step();
        bus.relock_ack = 1'b1;
        step();
        bus.relock_ack = 1'b0;
        chk("rand_ack_lost", bus.lock_lost, 0);
        wait_lock(1'b1);
      end
    end

    // Mid-operation reset while relock is pending
    lost_flag = 1'b0;
    for (int w = 0; w < LOSS_WIN && !lost_flag; w++)
      send_window(16'hFFFF, 0, lost_flag);
    chk("pre_rst_req", bus.relock_req, 1);
    rst = 1'b1;
    step();
    chk("midrst_req", bus.relock_req, 0);
    chk("midrst_lost", bus.lock_lost, 0);
    chk("midrst_bias", bus.bias, 0);
    chk("midrst_lock_ok", bus.lock_ok, 0);
    rst = 1'b0;
    bus.locked_in = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
